// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 16-bit restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_t;

  localparam int unsigned DivWidth   = 16;
  localparam int unsigned DivCntW    = $clog2(DivWidth + 1);
  localparam logic [15:0] DivDzQuot  = 16'hFFFF;
  localparam logic [15:0] DivMinNeg  = 16'h8000;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor on entry, so the 17-bit trial never aliases: bit WIDTH set means negative.
  always_comb begin
    shifted  = {rem, dvd_msb};
    trial    = shifted - {1'b0, divisor};
    q_bit    = ~trial[WIDTH];
    rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider16.sv
// Iterative 16-bit divider with start/busy/done handshake.
// Signed operation is built only when DIV_SIGNED_EN is defined; otherwise all ops are unsigned.
module seq_divider16
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dzFlag,
  output logic             overFlag
);

  div_state_t         state;
  logic [DivCntW-1:0] cnt_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               qneg_q, rneg_q, dz_q, ovf_q;

  logic [WIDTH-1:0]   a_mag, b_mag, rem_next, q_res, r_res;
  logic               q_neg, r_neg, ovf_hit, dz_hit, q_bit;

  // Operand conditioning at the accept edge.
  always_comb begin
    a_mag   = A;
    b_mag   = B;
    q_neg   = 1'b0;
    r_neg   = 1'b0;
    ovf_hit = 1'b0;
    dz_hit  = (B == '0);
`ifdef DIV_SIGNED_EN
    if (sign) begin
      a_mag   = A[WIDTH-1] ? -A : A;
      b_mag   = B[WIDTH-1] ? -B : B;
      q_neg   = A[WIDTH-1] ^ B[WIDTH-1];
      r_neg   = A[WIDTH-1];
      ovf_hit = (A == DivMinNeg) && (B == '1);
    end
`endif
  end

`ifndef DIV_SIGNED_EN
  logic unused_sign;
  assign unused_sign = sign;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_q),
    .dvd_msb (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_next(rem_next),
    .q_bit   (q_bit)
  );

  // Result selection for the FIX edge; the dz path parks the raw dividend in rem_q.
  always_comb begin
    q_res = dvd_q;
    r_res = rem_q;
    if (dz_q) begin
      q_res = DivDzQuot;
    end else if (ovf_q) begin
      q_res = DivMinNeg;
      r_res = '0;
    end else begin
      if (qneg_q) q_res = -dvd_q;
      if (rneg_q) r_res = -rem_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      Q        <= '0;
      R        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dzFlag   <= 1'b0;
      overFlag <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            busy   <= 1'b1;
            cnt_q  <= '0;
            dvd_q  <= a_mag;
            dvs_q  <= b_mag;
            qneg_q <= q_neg;
            rneg_q <= r_neg;
            dz_q   <= dz_hit;
            ovf_q  <= ovf_hit;
            rem_q  <= dz_hit ? A : '0;
            state  <= (dz_hit || ovf_hit) ? StFix : StCalc;
          end
        end
        StCalc: begin
          rem_q <= rem_next;
          dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == DivCntW'(WIDTH - 1)) state <= StFix;
        end
        StFix: begin
          Q        <= q_res;
          R        <= r_res;
          dzFlag   <= dz_q;
          overFlag <= ovf_q;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= StDone;
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: cycle-level behavioural model plus directed literal checks.
// Honours DIV_SIGNED_EN the same way the design does.
module tb_seq_divider16;

`ifdef DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] Q, R;
  logic        busy, done, dzFlag, overFlag;

  int vectors = 0;
  int miscompares = 0;

  seq_divider16 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sign    (sign),
    .A       (A),
    .B       (B),
    .Q       (Q),
    .R       (R),
    .busy    (busy),
    .done    (done),
    .dzFlag  (dzFlag),
    .overFlag(overFlag)
  );

  always #5 clk = ~clk;

  // Arithmetic reference for one operation.
  function automatic void ref_div(input logic [15:0] a, input logic [15:0] b, input logic s,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output bit dz, output bit ov);
    int sa, sb;
    dz = 0;
    ov = 0;
    if (b == 16'h0) begin
      q  = 16'hFFFF;
      r  = a;
      dz = 1;
    end else if (SignedEn && s && a == 16'h8000 && b == 16'hFFFF) begin
      q  = 16'h8000;
      r  = 16'h0000;
      ov = 1;
    end else if (SignedEn && s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 16'(sa / sb);
      r  = 16'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Timeline model: idle -> working (edges left until result write) -> done cycle -> idle.
  int          m_phase = 0;
  int          m_left = 0;
  logic        m_busy = 0, m_done = 0, m_dz = 0, m_ov = 0;
  logic [15:0] m_q = '0, m_r = '0;
  logic [15:0] p_q, p_r;
  bit          p_dz, p_ov;

  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_busy  = 0;
      m_done  = 0;
      m_dz    = 0;
      m_ov    = 0;
      m_q     = '0;
      m_r     = '0;
    end
    vectors++;
    if ({busy, done, dzFlag, overFlag, Q, R} !== {m_busy, m_done, m_dz, m_ov, m_q, m_r}) begin
      miscompares++;
      $display("FAIL cycle t=%0t busy/done/dz/ov/Q/R: got %b %b %b %b %h %h, want %b %b %b %b %h %h",
               $time, busy, done, dzFlag, overFlag, Q, R, m_busy, m_done, m_dz, m_ov, m_q, m_r);
    end
    if (!rst) begin
      case (m_phase)
        0: if (start === 1'b1) begin
          ref_div(A, B, sign, p_q, p_r, p_dz, p_ov);
          m_left  = (p_dz || p_ov) ? 1 : 17;
          m_busy  = 1;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_q     = p_q;
            m_r     = p_r;
            m_dz    = p_dz;
            m_ov    = p_ov;
            m_busy  = 0;
            m_done  = 1;
            m_phase = 2;
          end
        end
        default: begin
          m_done  = 0;
          m_phase = 0;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Present operands with start for exactly one sampling edge (edge 0), then scramble them.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(posedge clk);
    #2;
    A = a;
    B = b;
    sign = s;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    sign = 1'($urandom);
  endtask

  // Returns the edge index (after the current point) at which done is first seen high.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      miscompares++;
      $display("FAIL wait_done: got no done pulse within 40 cycles, want one");
    end
  endtask

  int r;
  int lat;

  initial begin
    @(posedge clk);
    #1;
    check("rst_Q", 32'(Q), 32'h0);
    check("rst_R", 32'(R), 32'h0);
    check("rst_ctl", {28'h0, busy, done, dzFlag, overFlag}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    start_op(16'd100, 16'd7, 1'b0);
    wait_done(lat);
    check("udiv_lat", 32'(lat), 32'd17);
    check("udiv_Q", 32'(Q), 32'd14);
    check("udiv_R", 32'(R), 32'd2);
    check("udiv_flags", {30'h0, dzFlag, overFlag}, 32'h0);
    check("udiv_busy", 32'(busy), 32'h0);

    start_op(16'hFF9C, 16'd7, 1'b1);
    wait_done(lat);
    check("sdiv_Q", 32'(Q), SignedEn ? 32'hFFF2 : 32'h2484);
    check("sdiv_R", 32'(R), SignedEn ? 32'hFFFE : 32'h0000);
    check("sdiv_flags", {30'h0, dzFlag, overFlag}, 32'h0);

    start_op(16'h1234, 16'h0000, 1'b0);
    wait_done(lat);
    check("dz_lat", 32'(lat), 32'd1);
    check("dz_QR", {Q, R}, 32'hFFFF_1234);
    check("dz_flags", {30'h0, dzFlag, overFlag}, 32'h2);

    start_op(16'h8000, 16'hFFFF, 1'b1);
    wait_done(lat);
    check("ovf_lat", 32'(lat), SignedEn ? 32'd1 : 32'd17);
    check("ovf_QR", {Q, R}, SignedEn ? 32'h8000_0000 : 32'h0000_8000);
    check("ovf_flags", {30'h0, dzFlag, overFlag}, SignedEn ? 32'h1 : 32'h0);

    start_op(16'h8000, 16'hFFFF, 1'b0);
    wait_done(lat);
    check("uovf_QR", {Q, R}, 32'h0000_8000);
    check("uovf_flags", {30'h0, dzFlag, overFlag}, 32'h0);

    // Second start at cycle 5 of an operation must be ignored.
    start_op(16'd1000, 16'd3, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    start = 1'b1;
    A = 16'd7;
    B = 16'd2;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(lat);
    check("restart_QR", {Q, R}, {16'd333, 16'd1});
    repeat (3) @(posedge clk);

    // Reset in the middle of an operation clears outputs immediately.
    start_op(16'hABCD, 16'h0013, 1'b0);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_QR", {Q, R}, 32'h0);
    check("midrst_ctl", {30'h0, busy, done}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done(lat);
    check("max_QR", {Q, R}, 32'hFFFF_0000);

    // Random traffic: start at any time, operands always moving, occasional reset pulses.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #2;
      rst   = ($urandom_range(599) == 0);
      start = ($urandom_range(2) == 0);
      sign  = 1'($urandom);
      r     = $urandom_range(7);
      A     = 16'($urandom);
      B     = 16'($urandom);
      case (r)
        0: B = 16'h0000;
        1: begin A = 16'h8000; B = 16'hFFFF; end
        2: B = ($urandom_range(1) == 0) ? 16'h0001 : 16'hFFFF;
        3: B = 16'($urandom_range(15));
        default: ;
      endcase
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
